// File: rtl/pc_sequencer.sv
// Next-PC controller: boot hold, redirects, stall buffering, halt/resume.
// Optional exception redirect enabled by defining PCSEQ_EXCEPTION_EN.
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned BOOT_CYCLES  = 2,
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_current,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        halt,
    input  logic        resume,
`ifdef PCSEQ_EXCEPTION_EN
    input  logic        exc_req,
`endif
    output logic        pc_enable,
    output logic [31:0] pc_next,
    output logic        flush,
    output logic        halted
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

    state_t      state, state_d;
    logic [3:0]  cnt, cnt_d;
    logic        pend_valid, pend_valid_d;
    logic [31:0] pend_target, pend_target_d;

    logic        redir_valid;
    logic [31:0] redir_target;
    logic [31:0] seq_pc;
    logic [31:0] nxt_raw;

    assign seq_pc = pc_current + 32'd4;

    always_comb begin
        redir_valid  = 1'b0;
        redir_target = seq_pc;
`ifdef PCSEQ_EXCEPTION_EN
        if (exc_req) begin
            redir_valid  = 1'b1;
            redir_target = EXC_VECTOR;
        end else
`endif
        if (jump) begin
            redir_valid  = 1'b1;
            redir_target = jump_target;
        end else if (branch_taken) begin
            redir_valid  = 1'b1;
            redir_target = branch_target;
        end
    end

    always_comb begin
        pc_enable     = 1'b0;
        flush         = 1'b0;
        nxt_raw       = seq_pc;
        state_d       = state;
        cnt_d         = cnt;
        pend_valid_d  = pend_valid;
        pend_target_d = pend_target;
        unique case (state)
            BOOT: begin
                flush   = 1'b1;
                nxt_raw = RESET_VECTOR;
                cnt_d   = cnt + 4'd1;
                if (cnt == BOOT_LAST) begin
                    pc_enable = 1'b1;
                    state_d   = RUN;
                    cnt_d     = 4'd0;
                end
            end
            RUN: begin
                if (stall) begin
                    if (redir_valid) begin
                        pend_valid_d  = 1'b1;
                        pend_target_d = redir_target;
                    end
                end else if (redir_valid) begin
                    // A fresh redirect supersedes any older buffered one
                    pc_enable    = 1'b1;
                    flush        = 1'b1;
                    nxt_raw      = redir_target;
                    pend_valid_d = 1'b0;
                end else if (pend_valid) begin
                    pc_enable    = 1'b1;
                    flush        = 1'b1;
                    nxt_raw      = pend_target;
                    pend_valid_d = 1'b0;
                end else if (halt) begin
                    state_d = HALT;
                end else begin
                    pc_enable = 1'b1;
                end
            end
            HALT: begin
`ifdef PCSEQ_EXCEPTION_EN
                if (exc_req) begin
                    pc_enable    = 1'b1;
                    flush        = 1'b1;
                    nxt_raw      = EXC_VECTOR;
                    pend_valid_d = 1'b0;
                    state_d      = RUN;
                end else
`endif
                if (resume) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = BOOT;
                cnt_d   = 4'd0;
            end
        endcase
    end

    assign pc_next = {nxt_raw[31:2], 2'b00};
    assign halted  = (state == HALT);

    // Falling edge so the PC register samples our outputs on the same edge
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= BOOT;
            cnt         <= 4'd0;
            pend_valid  <= 1'b0;
            pend_target <= 32'd0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            pend_valid  <= pend_valid_d;
            pend_target <= pend_target_d;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed scoreboard bench for pc_sequencer with a behavioural PC register.
module tb_pc_sequencer;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc_current;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        halt;
    logic        resume;
    logic        exc_req;
    logic        pc_enable;
    logic [31:0] pc_next;
    logic        flush;
    logic        halted;

    int vectors;
    int miscompares;

    typedef struct {
        string       tag;
        logic        en;
        logic [31:0] nxt;
        logic        fl;
        logic        hl;
    } exp_t;

    exp_t sb[$];

    pc_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc_current    (pc_current),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .halt          (halt),
        .resume        (resume),
`ifdef PCSEQ_EXCEPTION_EN
        .exc_req       (exc_req),
`endif
        .pc_enable     (pc_enable),
        .pc_next       (pc_next),
        .flush         (flush),
        .halted        (halted)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    // Behavioural PC register, written on the falling edge
    always @(negedge clk)
        if (pc_enable) pc_current <= pc_next;

    task automatic cmp(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic step(input string tag, input logic en,
                        input logic [31:0] nxt, input logic fl,
                        input logic hl);
        exp_t e;
        sb.push_back('{tag, en, nxt, fl, hl});
        #2;
        e = sb.pop_front();
        cmp({e.tag, ".pc_enable"}, {31'd0, pc_enable}, {31'd0, e.en});
        cmp({e.tag, ".pc_next"}, pc_next, e.nxt);
        cmp({e.tag, ".flush"}, {31'd0, flush}, {31'd0, e.fl});
        cmp({e.tag, ".halted"}, {31'd0, halted}, {31'd0, e.hl});
        @(negedge clk);
        #1;
    endtask

    task automatic chk_pc(input string tag, input logic [31:0] expv);
        cmp({tag, ".pc"}, pc_current, expv);
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        rst_n         = 1'b0;
        pc_current    = 32'hDEAD_BEE0;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'd0;
        jump          = 1'b0;
        jump_target   = 32'd0;
        halt          = 1'b0;
        resume        = 1'b0;
        exc_req       = 1'b0;

        step("reset", 1'b0, 32'h0, 1'b1, 1'b0);
        chk_pc("reset_hold", 32'hDEAD_BEE0);
        rst_n = 1'b1;
        step("boot1", 1'b0, 32'h0, 1'b1, 1'b0);
        chk_pc("boot1", 32'hDEAD_BEE0);
        step("boot2", 1'b1, 32'h0, 1'b1, 1'b0);
        chk_pc("boot2", 32'h0);
        step("seq4", 1'b1, 32'h4, 1'b0, 1'b0);
        step("seq8", 1'b1, 32'h8, 1'b0, 1'b0);
        step("seqc", 1'b1, 32'hC, 1'b0, 1'b0);
        step("seq10", 1'b1, 32'h10, 1'b0, 1'b0);
        chk_pc("seq", 32'h10);

        branch_taken = 1'b1; branch_target = 32'h40;
        jump = 1'b1; jump_target = 32'h100;
        step("jmp_over_br", 1'b1, 32'h100, 1'b1, 1'b0);
        jump = 1'b0;
        chk_pc("jmp_over_br", 32'h100);
        branch_target = 32'h23;
        step("br_mask", 1'b1, 32'h20, 1'b1, 1'b0);
        branch_taken = 1'b0;
        chk_pc("br_mask", 32'h20);

        stall = 1'b1;
        step("stall1", 1'b0, 32'h24, 1'b0, 1'b0);
        branch_taken = 1'b1; branch_target = 32'h80;
        step("stall2", 1'b0, 32'h24, 1'b0, 1'b0);
        branch_taken = 1'b0;
        step("stall3", 1'b0, 32'h24, 1'b0, 1'b0);
        chk_pc("stall_hold", 32'h20);
        stall = 1'b0;
        step("pend_load", 1'b1, 32'h80, 1'b1, 1'b0);
        chk_pc("pend_load", 32'h80);
        step("pend_clr", 1'b1, 32'h84, 1'b0, 1'b0);

        stall = 1'b1; jump = 1'b1; jump_target = 32'h300;
        step("ovw1", 1'b0, 32'h88, 1'b0, 1'b0);
        jump = 1'b0; branch_taken = 1'b1; branch_target = 32'h30;
        step("ovw2", 1'b0, 32'h88, 1'b0, 1'b0);
        branch_taken = 1'b0; stall = 1'b0;
        step("ovw_load", 1'b1, 32'h30, 1'b1, 1'b0);
        chk_pc("ovw_load", 32'h30);

        halt = 1'b1;
        step("halt_in", 1'b0, 32'h34, 1'b0, 1'b0);
        halt = 1'b0;
        stall = 1'b1; jump = 1'b1; jump_target = 32'h500;
        for (int i = 0; i < 5; i++)
            step("halted", 1'b0, 32'h34, 1'b0, 1'b1);
        stall = 1'b0; jump = 1'b0;
        chk_pc("halt_hold", 32'h30);
        resume = 1'b1;
        step("resume", 1'b0, 32'h34, 1'b0, 1'b1);
        resume = 1'b0;
        chk_pc("resume", 32'h30);
        step("post_resume", 1'b1, 32'h34, 1'b0, 1'b0);
        chk_pc("post_resume", 32'h34);

        halt = 1'b1; jump = 1'b1; jump_target = 32'h1000;
        step("halt_redir", 1'b1, 32'h1000, 1'b1, 1'b0);
        halt = 1'b0; jump = 1'b0;
        step("halt_dropped", 1'b1, 32'h1004, 1'b0, 1'b0);

        jump = 1'b1; jump_target = 32'hFFFF_FFFC;
        step("to_top", 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0);
        jump = 1'b0;
        step("wrap", 1'b1, 32'h0, 1'b0, 1'b0);
        chk_pc("wrap", 32'h0);

`ifdef PCSEQ_EXCEPTION_EN
        halt = 1'b1;
        step("exc_halt_in", 1'b0, 32'h4, 1'b0, 1'b0);
        halt = 1'b0; exc_req = 1'b1;
        step("exc_in_halt", 1'b1, 32'h80, 1'b1, 1'b1);
        exc_req = 1'b0;
        chk_pc("exc_in_halt", 32'h80);
        step("exc_run", 1'b1, 32'h84, 1'b0, 1'b0);
`endif

        stall = 1'b1; jump = 1'b1; jump_target = 32'h200;
        step("rst_stall", 1'b0, pc_current + 32'd4, 1'b0, 1'b0);
        rst_n = 1'b0;
        step("rst_mid", 1'b0, 32'h0, 1'b1, 1'b0);
        rst_n = 1'b1; stall = 1'b0; jump = 1'b0;
        step("reboot1", 1'b0, 32'h0, 1'b1, 1'b0);
        step("reboot2", 1'b1, 32'h0, 1'b1, 1'b0);
        chk_pc("reboot", 32'h0);
        step("reboot_seq", 1'b1, 32'h4, 1'b0, 1'b0);
        chk_pc("reboot_seq", 32'h4);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
